mux_8to1: RTL and testbench
===========================

MUX_8TO1 -- requirements
Module: mux_8to1

Interface
REQ-001 Parameter DATA_W, default 1: width in bits of each of the 8 data lanes.
REQ-002 Parameter REG_OUT, default 1: 1 = registered output, 0 = combinational output.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  capture enable for the output register (ignored when REG_OUT=0).
REQ-006 Port in  input  8*DATA_W  data lanes; lane k occupies bits [k*DATA_W +: DATA_W], lane 0 at LSB.
REQ-007 Port sel  input  3  lane select, unsigned 0..7.
REQ-008 Port out  output  DATA_W  selected lane.
REQ-009 Port out_valid  output  1  out holds a lane selected since the last reset.
REQ-010 Port order SHALL be clk, rst, en, in, sel, out, out_valid.

Function
REQ-011 Selection SHALL be out = lane[sel]; all 8 sel codes are legal, so there is no out-of-range case.
REQ-012 sel SHALL be exactly 3 bits; wider values driven by the parent are truncated to bits [2:0] (e.g. 4'b1000 selects lane 0).
REQ-013 REG_OUT=1: on a rising edge with rst=0 and en=1, out SHALL load lane[sel] and out_valid SHALL become 1; latency is exactly 1 cycle.
REQ-014 REG_OUT=1: on a rising edge with rst=0 and en=0, out and out_valid SHALL hold their values.
REQ-015 REG_OUT=1: changes on in or sel between edges SHALL NOT affect out.
REQ-016 REG_OUT=0: out SHALL equal lane[sel] combinationally with zero latency, and out_valid SHALL be the constant 1; rst and en have no effect.
REQ-017 X or Z on an unselected lane SHALL NOT propagate to out.

Reset
REQ-018 REG_OUT=1: when rst=1 at a rising edge, out SHALL become all-zeros and out_valid 0, regardless of en.
REQ-019 Reset SHALL take priority over en when both are asserted in the same cycle.
REQ-020 Asserting rst mid-operation SHALL discard the held value; the first edge with rst=0 and en=1 reloads normally.
REQ-021 No asynchronous reset path SHALL exist.

Structure
REQ-022 Package mux_8to1_pkg SHALL hold NUM_LANES=8 and SEL_W=3.
REQ-023 The select datapath SHALL be a single always_comb case or indexed part-select.
REQ-024 The output register SHALL be generated only when REG_OUT=1; no sub-module is required.

Verification
REQ-025 DATA_W=1, REG_OUT=0, in=8'b10001010 -> sel 001:1, 100:0, 110:0, 111:1, 000:0.
REQ-026 REG_OUT=1, en=1, same in, sel=111 -> out=1 and out_valid=1 one edge later; sel=100 -> out=0 on the next edge.
REQ-027 REG_OUT=1: rst=1 together with en=1 -> out=0 and out_valid=0 after the edge; release rst with sel=001 -> out=1 one edge later.
REQ-028 REG_OUT=1, en=0: toggle in and sel for 5 cycles -> out and out_valid stay unchanged.
REQ-029 DATA_W=4, in=32'h7654_3210: sweep sel 0..7 -> out=sel each time; drive X on all unselected lanes -> out shows no X.

Source files
------------

// File: rtl/mux_8to1_pkg.sv
// Shared constants for the 8-lane selector.
// Lane geometry lives here so the top and any parent agree on select width.
package mux_8to1_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

endpackage

// File: rtl/mux_8to1.sv
// 8:1 lane selector with an optional enable-gated output register.
// REG_OUT=0 gives a purely combinational path with out_valid tied high.
module mux_8to1
    import mux_8to1_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_LANES*DATA_W-1:0]   in,
    input  logic [SEL_W-1:0]              sel,
    output logic [DATA_W-1:0]             out,
    output logic                          out_valid
);

    logic [DATA_W-1:0] w_lane;

    // Part-select reads only the addressed lane, so X on other lanes never reaches out.
    always_comb begin
        w_lane = in[sel*DATA_W +: DATA_W];
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [DATA_W-1:0] r_out;
            logic              r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out   <= '0;
                    r_valid <= 1'b0;
                end else if (en) begin
                    r_out   <= w_lane;
                    r_valid <= 1'b1;
                end
            end

            assign out       = r_out;
            assign out_valid = r_valid;
        end else begin : g_comb
            logic w_unused;

            assign w_unused  = &{1'b0, clk, rst, en};
            assign out       = w_lane;
            assign out_valid = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_mux_8to1.sv
// Bench for mux_8to1: combinational and registered builds at widths 1 and 4,
// directed cases followed by randomized traffic against a lane-extraction model.
module tb_mux_8to1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  sel;
    logic [7:0]  in1;
    logic [31:0] in4;

    logic        c1_out, c1_v, r1_out, r1_v;
    logic [3:0]  c4_out, r4_out;
    logic        c4_v, r4_v;

    logic        m_r1_out, m_r1_v;
    logic [3:0]  m_r4_out;
    logic        m_r4_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_8to1 #(.DATA_W(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .en(en), .in(in1), .sel(sel), .out(c1_out), .out_valid(c1_v));
    mux_8to1 #(.DATA_W(1), .REG_OUT(1'b1)) u_r1 (
        .clk(clk), .rst(rst), .en(en), .in(in1), .sel(sel), .out(r1_out), .out_valid(r1_v));
    mux_8to1 #(.DATA_W(4), .REG_OUT(1'b0)) u_c4 (
        .clk(clk), .rst(rst), .en(en), .in(in4), .sel(sel), .out(c4_out), .out_valid(c4_v));
    mux_8to1 #(.DATA_W(4), .REG_OUT(1'b1)) u_r4 (
        .clk(clk), .rst(rst), .en(en), .in(in4), .sel(sel), .out(r4_out), .out_valid(r4_v));

    function automatic logic lane1(input logic [7:0] v, input int s);
        return 1'((v >> s) & 8'h01);
    endfunction

    function automatic logic [3:0] lane4(input logic [31:0] v, input int s);
        return 4'((v >> (4 * s)) & 32'h0000_000F);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge; the model applies reset/enable rules to the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_r1_out = 1'b0; m_r1_v = 1'b0;
            m_r4_out = 4'h0; m_r4_v = 1'b0;
        end else if (en) begin
            m_r1_out = lane1(in1, int'(sel)); m_r1_v = 1'b1;
            m_r4_out = lane4(in4, int'(sel)); m_r4_v = 1'b1;
        end
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_r1_out"}, 32'(r1_out), 32'(m_r1_out));
        check({tag, "_r1_v"},   32'(r1_v),   32'(m_r1_v));
        check({tag, "_r4_out"}, 32'(r4_out), 32'(m_r4_out));
        check({tag, "_r4_v"},   32'(r4_v),   32'(m_r4_v));
    endtask

    initial begin
        automatic int          sel_tab[5] = '{1, 4, 6, 7, 0};
        automatic logic        exp_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        automatic logic [3:0]  wide_sel;
        automatic logic [31:0] xin;

        m_r1_out = 1'b0; m_r1_v = 1'b0; m_r4_out = 4'h0; m_r4_v = 1'b0;
        rst = 1'b1; en = 1'b0; sel = 3'd0; in1 = 8'h00; in4 = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_r1_out", 32'(r1_out), 32'd0);
        check("rst_r1_v",   32'(r1_v),   32'd0);
        check("rst_r4_out", 32'(r4_out), 32'd0);
        check("rst_r4_v",   32'(r4_v),   32'd0);
        check("rst_c1_v",   32'(c1_v),   32'd1);

        // Combinational select, width 1
        rst = 1'b0;
        in1 = 8'b1000_1010;
        for (int i = 0; i < 5; i++) begin
            sel = 3'(sel_tab[i]);
            #1;
            check($sformatf("comb1_sel%0d", sel_tab[i]), 32'(c1_out), 32'(exp_tab[i]));
        end
        check("comb1_valid", 32'(c1_v), 32'd1);

        // Registered load, one-edge latency
        en = 1'b1; sel = 3'd7;
        #1;
        check("reg_pre_edge_v", 32'(r1_v), 32'd0);
        tick();
        check("reg_sel7_out", 32'(r1_out), 32'd1);
        check("reg_sel7_v",   32'(r1_v),   32'd1);
        sel = 3'd4;
        tick();
        check("reg_sel4_out", 32'(r1_out), 32'd0);
        sel = 3'd7;
        tick();
        check("reg_sel7b_out", 32'(r1_out), 32'd1);

        // Reset wins over enable, then reload
        rst = 1'b1; en = 1'b1;
        tick();
        check("rst_en_out", 32'(r1_out), 32'd0);
        check("rst_en_v",   32'(r1_v),   32'd0);
        check("rst_comb_unaffected", 32'(c1_out), 32'(lane1(in1, int'(sel))));
        check("rst_comb_v",          32'(c1_v),   32'd1);
        rst = 1'b0; sel = 3'd1;
        tick();
        check("reload_out", 32'(r1_out), 32'd1);
        check("reload_v",   32'(r1_v),   32'd1);

        // Hold with en=0 while inputs churn
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in1 = 8'($urandom); in4 = $urandom; sel = 3'($urandom_range(0, 7));
            tick();
            check("hold_r1_out", 32'(r1_out), 32'd1);
            check("hold_r1_v",   32'(r1_v),   32'd1);
            check_regs($sformatf("hold%0d", i));
        end

        // Width 4 sweep, then X on every unselected lane
        in4 = 32'h7654_3210;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("sweep4_sel%0d", s), 32'(c4_out), 32'(s));
        end
        for (int s = 0; s < 8; s++) begin
            xin = 'x;
            xin[4*s +: 4] = 4'(s);
            in4 = xin;
            sel = 3'(s);
            #1;
            check($sformatf("xlane_known%0d", s), 32'($isunknown(c4_out)), 32'd0);
            check($sformatf("xlane_val%0d", s),   32'(c4_out), 32'(s));
        end

        // A 4-bit code from a parent keeps only its low 3 bits
        in4 = 32'h7654_3210;
        wide_sel = 4'b1101;
        sel = wide_sel[2:0];
        #1;
        check("trunc_sel", 32'(c4_out), 32'd5);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            in1 = 8'($urandom);
            in4 = $urandom;
            sel = 3'($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 9) == 0);
            #1;
            check("rand_c1", 32'(c1_out), 32'(lane1(in1, int'(sel))));
            check("rand_c4", 32'(c4_out), 32'(lane4(in4, int'(sel))));
            tick();
            check_regs("rand");
            in4 = ~in4; in1 = ~in1; sel = sel + 3'd3;
            #2;
            check("midcycle_r4_out", 32'(r4_out), 32'(m_r4_out));
            check("midcycle_r1_out", 32'(r1_out), 32'(m_r1_out));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
